// File: rtl/i2s_master_tx.sv
// I2S master transmitter: divides the system clock into a bit clock and
// shifts one buffered stereo pair per frame out in I2S format.
module i2s_master_tx #(
    parameter int WS  = 16,
    parameter int DIV = 8
) (
    input  logic          iCLK_28,
    input  logic          mRST_N,
    input  logic [2*WS-1:0] iDATA,
    input  logic          iVALID,
    output logic          oREADY,
    output logic          AUD_BCLK,
    output logic          AUD_DACLRCK,
    output logic          AUD_DACDAT,
    output logic          oUNDERRUN
);

    localparam int FW = 2 * WS;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(FW);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] WS_B     = BW'(WS);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FW-1:0] sh_q, sh_d;
    logic [FW-1:0] buf_q, buf_d;
    logic          bclk_q, bclk_d;
    logic          lrck_q, lrck_d;
    logic          dat_q, dat_d;
    logic          full_q, full_d;
    logic          rdy_q, rdy_d;
    logic          und_q, und_d;

    logic tick;
    logic fall;
    logic frame;
    logic xfer;

    assign tick  = (div_q == DIV_LAST);
    assign fall  = tick & bclk_q;
    assign frame = fall & (bit_q == BIT_LAST);
    assign xfer  = iVALID & rdy_q;

    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        bclk_d = bclk_q ^ tick;
        bit_d  = bit_q;
        lrck_d = lrck_q;
        dat_d  = dat_q;
        sh_d   = sh_q;
        buf_d  = buf_q;
        full_d = full_q;
        und_d  = 1'b0;
        if (xfer) begin
            buf_d  = iDATA;
            full_d = 1'b1;
        end
        if (fall) begin
            bit_d  = frame ? '0 : bit_q + 1'b1;
            lrck_d = (bit_d >= WS_B);
            // MSB of the shifter is the next bit; at a wrap it holds the
            // previous word's LSB, which gives the one-bit I2S delay.
            dat_d  = sh_q[FW-1];
            if (frame) begin
                if (full_q) begin
                    sh_d   = buf_q;
                    full_d = 1'b0;
                end else begin
                    sh_d  = '0;
                    und_d = 1'b1;
                end
            end else begin
                sh_d = {sh_q[FW-2:0], 1'b0};
            end
        end
        rdy_d = ~full_d;
    end

    always_ff @(posedge iCLK_28 or negedge mRST_N) begin
        if (!mRST_N) begin
            div_q  <= '0;
            bit_q  <= BIT_LAST;
            sh_q   <= '0;
            buf_q  <= '0;
            bclk_q <= 1'b0;
            lrck_q <= 1'b1;
            dat_q  <= 1'b0;
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
            und_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            buf_q  <= buf_d;
            bclk_q <= bclk_d;
            lrck_q <= lrck_d;
            dat_q  <= dat_d;
            full_q <= full_d;
            rdy_q  <= rdy_d;
            und_q  <= und_d;
        end
    end

    assign oREADY      = rdy_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign oUNDERRUN   = und_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Scoreboard bench for i2s_master_tx (WS=16, DIV=2): stimulus queues
// expected frames, a bit-clock monitor rebuilds and compares them.
module tb_i2s_master_tx;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        valid;
    logic        oREADY;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        oUNDERRUN;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] w;
        logic        u;
    } exp_t;

    exp_t q[$];

    i2s_master_tx #(.WS(16), .DIV(2)) dut (
        .iCLK_28    (clk),
        .mRST_N     (rst_n),
        .iDATA      (data),
        .iVALID     (valid),
        .oREADY     (oREADY),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT (AUD_DACDAT),
        .oUNDERRUN  (oUNDERRUN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic u);
        exp_t e;
        e.w = w;
        e.u = u;
        q.push_back(e);
    endtask

    task automatic wait_f();
        logic p;
        logic got;
        p   = AUD_DACLRCK;
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (p && !AUD_DACLRCK) got = 1'b1;
            p = AUD_DACLRCK;
        end
        chk("wait_frame", 32'(got), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bclk"}, 32'(AUD_BCLK), 32'd0);
        chk({tag, "_lrck"}, 32'(AUD_DACLRCK), 32'd1);
        chk({tag, "_dat"}, 32'(AUD_DACDAT), 32'd0);
        chk({tag, "_ready"}, 32'(oREADY), 32'd1);
        chk({tag, "_und"}, 32'(oUNDERRUN), 32'd0);
    endtask

    // Monitor: tracks falling bit-clock events on its own bit count
    int          mcnt = 31;
    int          gap = 0;
    logic        pb = 1'b0;
    logic        tog = 1'b0;
    logic        inf = 1'b0;
    logic        fl;
    logic        u;
    logic [31:0] w;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt = 31;
            gap  = 0;
            pb   = 1'b0;
            tog  = 1'b0;
            inf  = 1'b0;
        end else begin
            gap++;
            fl = 1'b0;
            if (AUD_BCLK !== pb) begin
                if (tog) chk("bclk_half", 32'(gap), 32'd2);
                tog = 1'b1;
                gap = 0;
                fl  = pb;
            end
            pb = AUD_BCLK;
            if (fl) begin
                mcnt = (mcnt == 31) ? 0 : mcnt + 1;
                chk("lrck", 32'(AUD_DACLRCK), 32'(mcnt >= 16));
                if (mcnt == 0) begin
                    if (inf) begin
                        w[0] = AUD_DACDAT;
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            chk("frame_word", w, e.w);
                            chk("frame_und", 32'(u), 32'(e.u));
                        end
                    end
                    inf = 1'b1;
                    u   = oUNDERRUN;
                    w   = '0;
                end else begin
                    w[32-mcnt] = AUD_DACDAT;
                end
            end else begin
                chk("und_stray", 32'(oUNDERRUN), 32'd0);
            end
        end
    end

    logic [31:0] ws [4];
    int          i;
    int          cyc;
    int          last;
    logic        x;

    initial begin
        ws[0] = 32'h1234_5678;
        ws[1] = 32'h8000_0001;
        ws[2] = 32'hFFFF_0000;
        ws[3] = 32'h0F0F_F0F0;
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");

        // Pair loaded before the first frame boundary
        @(negedge clk);
        rst_n = 1'b1;
        data  = 32'hA5F0_0F5A;
        valid = 1'b1;
        push(32'hA5F0_0F5A, 1'b0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("ready_drop", 32'(oREADY), 32'd0);
        wait_f();
        chk("ready_back", 32'(oREADY), 32'd1);

        push(32'h0, 1'b1);
        wait_f();

        // Streaming: one transfer per frame, 128 clocks apart
        for (int k = 0; k < 4; k++) push(ws[k], 1'b0);
        valid = 1'b1;
        data  = ws[0];
        i     = 0;
        cyc   = 0;
        last  = 0;
        while (i < 4 && cyc < 1000) begin
            x = oREADY;
            @(posedge clk);
            cyc++;
            #1;
            if (x) begin
                if (i > 0) chk("xfer_gap", 32'(cyc - last), 32'd128);
                last = cyc;
                i++;
                data = (i < 4) ? ws[i % 4] : '0;
            end
        end
        valid = 1'b0;
        chk("stream_done", 32'(i), 32'd4);
        push(32'h0, 1'b1);
        wait_f();
        wait_f();

        // Pair offered exactly in the frame-boundary cycle
        repeat (127) @(posedge clk);
        #1;
        valid = 1'b1;
        data  = 32'hDEAD_BEEF;
        push(32'h0, 1'b1);
        push(32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("f_und", 32'(oUNDERRUN), 32'd1);
        chk("f_ready", 32'(oREADY), 32'd0);
        wait_f();
        wait_f();

        // Buffer a pair, then reset at bit count 20
        valid = 1'b1;
        data  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("q_ready", 32'(oREADY), 32'd0);
        repeat (79) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(32'h0, 1'b1);

        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
